// File: rtl/vga_pkg.sv
// Shared constants and types for the 1024x768@70 video path: raster timing,
// pixel packing into VRAM words, and the scanline fetch state encoding.
package vga_pkg;

    // 1024x768 @ 70 Hz raster timing, 75 MHz pixel clock
    localparam int H_ACTIVE = 1024;
    localparam int H_FRONT  = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BACK   = 144;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_ACTIVE = 768;
    localparam int V_FRONT  = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BACK   = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Framebuffer packing: four 8-bit pixels per VRAM word, byte 0 shown first
    localparam int PIX_W          = 8;
    localparam int PIX_PER_WORD   = 4;
    localparam int WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD;
    localparam int LINES          = V_ACTIVE;

    // Scanline fetch sequencing
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vram_fifo.sv
// Two-entry word FIFO between the VRAM read port and the pixel serialiser.
// Occupancy is exposed so the fetcher can throttle itself; flush empties it
// in one clock when a new scanline starts.
module vram_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    // Pointer and occupancy bookkeeping; flush overrides any push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Word storage; contents need no reset because count gates every use of head
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/vram_scan_arbiter.sv
// Shares a single-port VRAM between scanline prefetch and a CPU port.
// Display fetches always win; every other slot may serve one CPU access,
// acknowledged the following cycle. Prefetched words are serialised into
// 8-bit pixels, one per active-video clock, with one clock of latency.
module vram_scan_arbiter #(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
    parameter int LINES          = vga_pkg::LINES,
    parameter int BASE           = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_pre,
    input  logic [9:0]        line_idx,
    input  logic              avr,
    output logic [7:0]        pix_data,
    output logic              underrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import vga_pkg::*;

    localparam int         WCNT_W    = $clog2(WORDS_PER_LINE + 1);
    localparam logic [10:0] LINES_L  = 11'(LINES);
    localparam logic [1:0] LAST_BYTE = 2'(PIX_PER_WORD - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_LINE - 1);

    fetch_state_t      fstate;
    logic [ADDR_W-1:0] word_ptr;
    logic [ADDR_W-1:0] line_base;
    logic [WCNT_W-1:0] words_issued;

    logic              line_start;
    logic              disp_req;
    logic              cpu_grant;
    logic              disp_vld_p1;
    logic              cpu_we_p1;

    logic              fifo_pop;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [1:0]        byte_idx;

    function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] w,
                                             input logic [1:0]        idx);
        return w[8*idx +: 8];
    endfunction

    // Lines at or beyond the visible count are ignored entirely
    assign line_start = line_pre && ({1'b0, line_idx} < LINES_L);
    assign line_base  = ADDR_W'(BASE) + ADDR_W'(line_idx) * ADDR_W'(WORDS_PER_LINE);

    // Keep at most two words buffered or in flight; that bounds FIFO depth
    assign disp_req  = (fstate == FETCH) && ((fifo_count + {1'b0, disp_vld_p1}) < 2'd2);
    assign cpu_grant = cpu_req && !cpu_ack && !disp_req;

    assign fifo_pop  = avr && (fifo_count != 2'd0) && (byte_idx == LAST_BYTE);
    assign cpu_rdata = (cpu_ack && !cpu_we_p1) ? ram_rdata : '0;

    // VRAM port mux: display fetch has priority over the CPU grant
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (disp_req) begin
            ram_en   = 1'b1;
            ram_addr = word_ptr;
        end else if (cpu_grant) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_we ? cpu_wdata : '0;
        end
    end

    // Fetch sequencer: a valid line_pre restarts the line from any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate       <= IDLE;
            word_ptr     <= '0;
            words_issued <= '0;
        end else if (line_start) begin
            fstate       <= FETCH;
            word_ptr     <= line_base;
            words_issued <= '0;
        end else begin
            case (fstate)
                FETCH: begin
                    if (disp_req) begin
                        word_ptr     <= word_ptr + ADDR_W'(1);
                        words_issued <= words_issued + WCNT_W'(1);
                        if (words_issued == LAST_WORD) fstate <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((fifo_count == 2'd0) && !disp_vld_p1 && !avr) fstate <= IDLE;
                end
                default: fstate <= IDLE;
            endcase
        end
    end

    // Read-return tracking: which requester owns next cycle's ram_rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_vld_p1 <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_we_p1   <= 1'b0;
        end else begin
            disp_vld_p1 <= disp_req && !line_start;
            cpu_ack     <= cpu_grant;
            cpu_we_p1   <= cpu_grant && cpu_we;
        end
    end

    vram_fifo #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (disp_vld_p1),
        .push_data (ram_rdata),
        .pop       (fifo_pop),
        .flush     (line_start),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Pixel serialiser: one byte per active clock, sticky underrun on starvation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data <= 8'h00;
            underrun <= 1'b0;
            byte_idx <= 2'd0;
        end else begin
            pix_data <= 8'h00;
            if (avr) begin
                if (fifo_count != 2'd0) begin
                    pix_data <= word_byte(fifo_head, byte_idx);
                    byte_idx <= (byte_idx == LAST_BYTE) ? 2'd0 : byte_idx + 2'd1;
                end else begin
                    underrun <= 1'b1;
                end
            end
            if (line_start) byte_idx <= 2'd0;
        end
    end

endmodule
